// File: rtl/riscv_multicycle_ctrl.sv
// riscv_multicycle_ctrl
// Multi-cycle RISC-V control FSM. It shares one memory port between
// instruction fetch and data access, stalls on mem_ready_i, and decodes
// lw/sw/R-type/I-type ALU/beq/bne/jal. Unknown encodings trap until reset.
// It also keeps a wrapping count of retired instructions.
// Optional feature macro: RISCV_MEM_TIMEOUT_EN. When it is defined, a memory
// wait that lasts TIMEOUT_CYCLES cycles traps with bus_error_o set.
module riscv_multicycle_ctrl #(
  parameter int RETIRE_CNT_W = 32
`ifdef RISCV_MEM_TIMEOUT_EN
  , parameter int TIMEOUT_CYCLES = 16
`endif
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [6:0]              op_i,
  input  logic [2:0]              funct3_i,
  input  logic                    funct7_i,
  input  logic                    zero_i,
  input  logic                    mem_ready_i,
  output logic                    mem_req_o,
  output logic                    MemWrite_o,
  output logic                    AdrSrc_o,
  output logic                    IRWrite_o,
  output logic                    PCWrite_o,
  output logic                    RegWrite_o,
  output logic [1:0]              ImmSrc_o,
  output logic [1:0]              ALUSrcA_o,
  output logic [1:0]              ALUSrcB_o,
  output logic [1:0]              ResultSrc_o,
  output logic [2:0]              ALUControl_o,
  output logic                    illegal_op_o,
  output logic                    bus_error_o,
  output logic                    instr_retired_o,
  output logic [RETIRE_CNT_W-1:0] retired_count_o
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECR    = 4'd6;
  localparam logic [3:0] S_EXECI    = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;
  localparam logic [3:0] S_TRAP     = 4'd11;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  logic [3:0]              state_q, state_d;
  logic [RETIRE_CNT_W-1:0] retireCnt_q, retireCnt_d;
  logic [2:0]              aluDecoded;
  logic                    aluIllegal;
  logic                    memReq;
  logic                    timeoutHit;

  // ALU operation for EXECR/EXECI, plus a flag for funct3 values we do not support.
  always_comb begin
    aluDecoded = ALU_ADD;
    aluIllegal = 1'b0;
    case (funct3_i)
      3'b000:  aluDecoded = (funct7_i && (op_i == OP_RTYPE)) ? ALU_SUB : ALU_ADD;
      3'b010:  aluDecoded = ALU_SLT;
      3'b110:  aluDecoded = ALU_OR;
      3'b111:  aluDecoded = ALU_AND;
      default: aluIllegal = 1'b1;
    endcase
  end

  // Per-state datapath controls and next state. Everything is forced low while reset is held.
  always_comb begin
    state_d         = state_q;
    memReq          = 1'b0;
    MemWrite_o      = 1'b0;
    AdrSrc_o        = 1'b0;
    IRWrite_o       = 1'b0;
    PCWrite_o       = 1'b0;
    RegWrite_o      = 1'b0;
    ImmSrc_o        = 2'b00;
    ALUSrcA_o       = 2'b00;
    ALUSrcB_o       = 2'b00;
    ResultSrc_o     = 2'b00;
    ALUControl_o    = ALU_ADD;
    instr_retired_o = 1'b0;
    case (state_q)
      S_FETCH: begin
        memReq      = 1'b1;
        ALUSrcB_o   = 2'b10;
        ResultSrc_o = 2'b10;
        if (mem_ready_i) begin
          IRWrite_o = 1'b1;
          PCWrite_o = 1'b1;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b01;
        ImmSrc_o  = 2'b10;
        case (op_i)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          default:           state_d = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA_o = 2'b10;
        ALUSrcB_o = 2'b01;
        ImmSrc_o  = (op_i == OP_STORE) ? 2'b01 : 2'b00;
        state_d   = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        memReq   = 1'b1;
        AdrSrc_o = 1'b1;
        if (mem_ready_i) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        ResultSrc_o     = 2'b01;
        RegWrite_o      = 1'b1;
        instr_retired_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEMWRITE: begin
        memReq     = 1'b1;
        MemWrite_o = 1'b1;
        AdrSrc_o   = 1'b1;
        if (mem_ready_i) begin
          instr_retired_o = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_EXECR, S_EXECI: begin
        ALUSrcA_o    = 2'b10;
        ALUSrcB_o    = (state_q == S_EXECI) ? 2'b01 : 2'b00;
        ALUControl_o = aluDecoded;
        state_d      = aluIllegal ? S_TRAP : S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite_o      = 1'b1;
        instr_retired_o = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA_o    = 2'b10;
        ALUControl_o = ALU_SUB;
        if (funct3_i == 3'b000 || funct3_i == 3'b001) begin
          PCWrite_o       = (funct3_i == 3'b000) ? zero_i : !zero_i;
          instr_retired_o = 1'b1;
          state_d         = S_FETCH;
        end else begin
          state_d = S_TRAP;
        end
      end
      S_JAL: begin
        ALUSrcA_o = 2'b01;
        ALUSrcB_o = 2'b10;
        ImmSrc_o  = 2'b11;
        PCWrite_o = 1'b1;
        state_d   = S_ALUWB;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
    if (timeoutHit) state_d = S_TRAP;
    mem_req_o = memReq;
    if (!rst_ni) begin
      mem_req_o       = 1'b0;
      MemWrite_o      = 1'b0;
      AdrSrc_o        = 1'b0;
      IRWrite_o       = 1'b0;
      PCWrite_o       = 1'b0;
      RegWrite_o      = 1'b0;
      ImmSrc_o        = 2'b00;
      ALUSrcA_o       = 2'b00;
      ALUSrcB_o       = 2'b00;
      ResultSrc_o     = 2'b00;
      ALUControl_o    = 3'b000;
      instr_retired_o = 1'b0;
    end
  end

`ifdef RISCV_MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
  logic              busErr_q, busErr_d;

  assign timeoutHit = memReq && !mem_ready_i && (waitCnt_q == WAIT_LAST);

  // Stall counter restarts whenever the state changes and advances on every unanswered request.
  always_comb begin
    waitCnt_d = waitCnt_q;
    if (state_d != state_q)          waitCnt_d = '0;
    else if (memReq && !mem_ready_i) waitCnt_d = waitCnt_q + 1'b1;
    busErr_d = busErr_q | timeoutHit;
  end

  // Stall counter and sticky bus-error flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      waitCnt_q <= '0;
      busErr_q  <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      busErr_q  <= busErr_d;
    end
  end

  assign bus_error_o  = busErr_q;
  assign illegal_op_o = (state_q == S_TRAP) && !busErr_q;
`else
  assign timeoutHit   = 1'b0;
  assign bus_error_o  = 1'b0;
  assign illegal_op_o = (state_q == S_TRAP);
`endif

  // The retire counter wraps naturally at its width.
  always_comb begin
    retireCnt_d = retireCnt_q;
    if (instr_retired_o) retireCnt_d = retireCnt_q + RETIRE_CNT_W'(1);
  end

  // State register and retire counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_FETCH;
      retireCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      retireCnt_q <= retireCnt_d;
    end
  end

  assign retired_count_o = retireCnt_q;

endmodule

// File: tb/tb_riscv_multicycle_ctrl.sv
// tb_riscv_multicycle_ctrl
// Random instruction stream against a transaction-level model. For each
// instruction the model predicts latency, handshake counts, and pulse counts
// from the instruction class and the memory delays.
module tb_riscv_multicycle_ctrl;
  localparam int CNT_W = 4;

  logic             clk, rst_n;
  logic [6:0]       op;
  logic [2:0]       funct3;
  logic             funct7, zero, mem_ready;
  logic             mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]       ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0]       ALUControl;
  logic             illegal_op, bus_error, instr_retired;
  logic [CNT_W-1:0] retired_count;

  int checksTotal  = 0;
  int checksPassed = 0;
  int modelCount   = 0;

  riscv_multicycle_ctrl #(.RETIRE_CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .op_i(op), .funct3_i(funct3), .funct7_i(funct7),
    .zero_i(zero), .mem_ready_i(mem_ready), .mem_req_o(mem_req), .MemWrite_o(MemWrite),
    .AdrSrc_o(AdrSrc), .IRWrite_o(IRWrite), .PCWrite_o(PCWrite), .RegWrite_o(RegWrite),
    .ImmSrc_o(ImmSrc), .ALUSrcA_o(ALUSrcA), .ALUSrcB_o(ALUSrcB), .ResultSrc_o(ResultSrc),
    .ALUControl_o(ALUControl), .illegal_op_o(illegal_op), .bus_error_o(bus_error),
    .instr_retired_o(instr_retired), .retired_count_o(retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checksTotal++;
    if (observed === expected) checksPassed++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
  endtask

  // Hold reset low for one cycle, check the quiet reset outputs, and release on a falling edge.
  task automatic applyReset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("reset_mem_req", mem_req, 0);
    checkOutput("reset_count", retired_count, 0);
    checkOutput("reset_illegal", illegal_op, 0);
    checkOutput("reset_pcwrite", PCWrite, 0);
    modelCount = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Run one instruction. The bench acts as memory, answering the k-th request after d[k] stall cycles.
  // The task starts just after a falling edge with the DUT in FETCH.
  task automatic applyStimulus(input logic [6:0] iOp, input logic [2:0] iF3, input logic iF7,
                               input logic iZero, input int d1, input int d2);
    int cycles = 0, memReqCycles = 0, irw = 0, pcw = 0, regw = 0, memw = 0;
    int accIdx = 0, waitCnt = 0;
    logic [2:0] lastAlu = 0, prevAlu = 0, aluAtRetire = 0;
    logic [1:0] resSrcAtWrite = 0;
    logic retired = 0, trapped = 0;
    bit isLoad, isStore, isR, isI, isBr, isJal, aluOk, brOk, expTrap, taken;
    logic [2:0] expAlu;
    int fetchLen, expCycles, trapHeld;
    string nm;

    // Predict the outcome from the instruction class.
    isLoad = (iOp == 7'b0000011); isStore = (iOp == 7'b0100011);
    isR = (iOp == 7'b0110011);    isI = (iOp == 7'b0010011);
    isBr = (iOp == 7'b1100011);   isJal = (iOp == 7'b1101111);
    aluOk = (iF3 == 3'd0) || (iF3 == 3'd2) || (iF3 == 3'd6) || (iF3 == 3'd7);
    brOk = (iF3 == 3'd0) || (iF3 == 3'd1);
    expTrap = !(isLoad || isStore || isR || isI || isBr || isJal) ||
              ((isR || isI) && !aluOk) || (isBr && !brOk);
    taken = isBr && ((iF3 == 3'd0) ? iZero : !iZero);
    expAlu = (iF3 == 3'd2) ? 3'b101 : (iF3 == 3'd6) ? 3'b011 : (iF3 == 3'd7) ? 3'b010 :
             (isR && iF7) ? 3'b001 : 3'b000;
    fetchLen = d1 + 1;
    if (expTrap)              expCycles = fetchLen + ((isR || isI || isBr) ? 3 : 2);
    else if (isLoad)          expCycles = fetchLen + 3 + d2 + 1;
    else if (isStore)         expCycles = fetchLen + 2 + d2 + 1;
    else if (isBr)            expCycles = fetchLen + 2;
    else                      expCycles = fetchLen + 3;
    nm = $sformatf("op%b_f%0d", iOp, iF3);

    op = iOp; funct3 = iF3; funct7 = iF7; zero = iZero;
    while (1) begin
      #1;
      cycles++;
      if (mem_req) mem_ready = (waitCnt == ((accIdx == 0) ? d1 : d2));
      else         mem_ready = 1'($urandom_range(0, 1));
      #1;
      if (cycles == 1) checkOutput({nm, "_count_start"}, retired_count, modelCount % (1 << CNT_W));
      if (mem_req) memReqCycles++;
      if (IRWrite) irw++;
      if (PCWrite) pcw++;
      if (MemWrite) memw++;
      if (RegWrite) begin regw++; resSrcAtWrite = ResultSrc; end
      prevAlu = lastAlu; lastAlu = ALUControl;
      if (mem_req && mem_ready) begin accIdx++; waitCnt = 0; end
      else if (mem_req) waitCnt++;
      if (instr_retired) begin retired = 1; aluAtRetire = ALUControl; break; end
      if (illegal_op) begin trapped = 1; break; end
      if (cycles > 60) break;
      @(negedge clk);
    end

    if (!retired && !trapped) checkOutput({nm, "_budget"}, 0, 1);
    checkOutput({nm, "_cycles"}, cycles, expCycles);
    checkOutput({nm, "_trapped"}, trapped, expTrap);
    checkOutput({nm, "_memreq"}, memReqCycles, fetchLen + ((!expTrap && (isLoad || isStore)) ? d2 + 1 : 0));
    checkOutput({nm, "_irwrite"}, irw, 1);
    checkOutput({nm, "_pcwrite"}, pcw, expTrap ? 1 : (1 + (taken ? 1 : 0) + (isJal ? 1 : 0)));
    checkOutput({nm, "_regwrite"}, regw, (!expTrap && (isLoad || isR || isI || isJal)) ? 1 : 0);
    checkOutput({nm, "_memwrite"}, memw, (!expTrap && isStore) ? d2 + 1 : 0);
    if (!expTrap && (isLoad || isR || isI || isJal))
      checkOutput({nm, "_resultsrc"}, resSrcAtWrite, isLoad ? 2'b01 : 2'b00);
    if (!expTrap && (isR || isI)) checkOutput({nm, "_alu"}, prevAlu, expAlu);
    if (!expTrap && isBr) checkOutput({nm, "_branch_alu"}, aluAtRetire, 3'b001);
    @(negedge clk);

    if (retired) modelCount++;
    if (trapped) begin
      trapHeld = 0;
      for (int i = 0; i < 8; i++) begin
        #1;
        mem_ready = 1'($urandom_range(0, 1));
        #1;
        if (!mem_req && illegal_op && !instr_retired) trapHeld++;
        @(negedge clk);
      end
      checkOutput({nm, "_trap_held"}, trapHeld, 8);
      applyReset();
    end
  endtask

  initial begin
    logic [6:0] opTable [7];
    logic [6:0] rOp;
    opTable = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111, 7'b1111111};
    rst_n = 1'b0; mem_ready = 1'b0; op = 0; funct3 = 0; funct7 = 0; zero = 0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("por_mem_req", mem_req, 0);
    checkOutput("por_count", retired_count, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases: add, delayed lw, beq/bne with zero set, illegal opcode, then a counter wrap.
    applyStimulus(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0);
    applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 3, 3);
    applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
    applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0);
    applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 1, 0);
    for (int i = 0; i < 18; i++) applyStimulus(7'b0010011, 3'b000, 1'b0, 1'b0, 0, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 60; i++) begin
      rOp = opTable[$urandom_range(0, 6)];
      if (rOp == 7'b1111111) rOp = 7'($urandom);
      applyStimulus(rOp, 3'($urandom), 1'($urandom), 1'($urandom), $urandom_range(0, 4), $urandom_range(0, 4));
    end

`ifdef RISCV_MEM_TIMEOUT_EN
    // A fetch that never completes must trap with bus_error after 16 stalled cycles.
    mem_ready = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      #2;
      if (i == 16) checkOutput("timeout_pre", bus_error, 0);
      if (i == 17) begin
        checkOutput("timeout_bus_error", bus_error, 1);
        checkOutput("timeout_illegal", illegal_op, 0);
        checkOutput("timeout_mem_req", mem_req, 0);
      end
      @(negedge clk);
    end
    applyReset();
`else
    // Without the timeout feature a fetch simply waits.
    mem_ready = 1'b0;
    repeat (100) @(negedge clk);
    #1;
    checkOutput("nowait_mem_req", mem_req, 1);
    checkOutput("nowait_bus_error", bus_error, 0);
    checkOutput("nowait_illegal", illegal_op, 0);
`endif

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end
endmodule
